pll_lock_detect: RTL and testbench

PLL_LOCK_DETECT -- requirements
Module: pll_lock_detect

---
 rtl/pll_pkg.sv | 17 +
 rtl/pll_ref_sync.sv | 27 ++
 rtl/pll_lock_detect.sv | 136 +++++++++++++
 tb/tb_pll_lock_detect.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared state encoding and default parameters for the PLL lock detector.
package pll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_LOCKED  = 2'd3
  } pll_state_t;

  localparam int DEF_MULT       = 8;
  localparam int DEF_TOL        = 1;
  localparam int DEF_LOCK_CNT   = 16;
  localparam int DEF_UNLOCK_CNT = 2;
  localparam int DEF_CNT_W      = 8;

endpackage

// File: rtl/pll_ref_sync.sv
// Two-flop synchronizer for the reference clock followed by a registered
// rising-edge detector; fixed 3-cycle latency from REF to rise.
module pll_ref_sync (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic rise
);

  logic ref_p0, ref_p1, ref_p2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ref_p0 <= 1'b0;
      ref_p1 <= 1'b0;
      ref_p2 <= 1'b0;
      rise   <= 1'b0;
    end else begin
      // p0/p1: metastability settle; p2: previous sample for edge detect
      ref_p0 <= d;
      ref_p1 <= ref_p0;
      ref_p2 <= ref_p1;
      rise   <= ref_p1 & ~ref_p2;
    end
  end

endmodule

// File: rtl/pll_lock_detect.sv
// PLL lock detector: measures REF period in CLK cycles and declares lock
// after LOCK_CNT consecutive in-tolerance periods.
module pll_lock_detect
  import pll_pkg::*;
#(
  parameter int MULT       = DEF_MULT,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT = DEF_UNLOCK_CNT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REF,
  input  logic             ENb_VCO,
  output logic             LOCK,
  output logic [CNT_W-1:0] REF_CYC,
  output logic             CNT_VALID,
  output logic             ERR
);

  localparam int GW   = $clog2(LOCK_CNT + 1);
  localparam int BW   = $clog2(UNLOCK_CNT + 1);
  localparam int LO_I = (MULT > TOL) ? MULT - TOL : 0;
  localparam logic [CNT_W:0] LO_V  = (CNT_W+1)'(LO_I);
  localparam logic [CNT_W:0] HI_V  = (CNT_W+1)'(MULT + TOL);
  localparam logic [CNT_W:0] SAT_V = (CNT_W+1)'(4 * MULT);

  // Extra MSB keeps the bound compare free of wrap/underflow effects.
  function automatic logic in_tol(input logic [CNT_W:0] cyc);
    return (cyc >= LO_V) && (cyc <= HI_V);
  endfunction

  pll_state_t       state, state_nx;
  logic             ref_rise;
  logic [CNT_W-1:0] per_cnt, per_nx;
  logic [CNT_W:0]   cnt_inc;
  logic [GW-1:0]    good_cnt, good_nx, good_inc;
  logic [BW-1:0]    bad_cnt, bad_nx, bad_inc;
  logic [CNT_W-1:0] ref_cyc_nx;
  logic             valid_nx, err_nx;
  logic             measuring, timeout, period_end, period_good;

  pll_ref_sync u_sync (
    .CLK  (CLK),
    .RST  (RST),
    .d    (REF),
    .rise (ref_rise)
  );

  assign measuring   = (state == ST_ACQUIRE) || (state == ST_LOCKED);
  assign cnt_inc     = {1'b0, per_cnt} + 1'b1;
  // A coincident edge wins over saturation and is captured normally.
  assign timeout     = (cnt_inc == SAT_V) && !ref_rise;
  assign period_end  = measuring && ENb_VCO && (ref_rise || timeout);
  assign period_good = ref_rise && in_tol(cnt_inc);
  assign good_inc    = (good_cnt == GW'(LOCK_CNT)) ? good_cnt : good_cnt + 1'b1;
  assign bad_inc     = (bad_cnt == BW'(UNLOCK_CNT)) ? bad_cnt : bad_cnt + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!ENb_VCO) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_nx = ST_ARM;
        ST_ARM:     if (ref_rise) state_nx = ST_ACQUIRE;
        ST_ACQUIRE: if (period_end && period_good && good_inc == GW'(LOCK_CNT))
                      state_nx = ST_LOCKED;
        ST_LOCKED:  if (period_end && !period_good && bad_inc == BW'(UNLOCK_CNT))
                      state_nx = ST_ACQUIRE;
        default:    state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    per_nx     = per_cnt;
    good_nx    = good_cnt;
    bad_nx     = bad_cnt;
    ref_cyc_nx = REF_CYC;
    valid_nx   = 1'b0;
    err_nx     = 1'b0;
    if (!ENb_VCO || !measuring) begin
      per_nx  = '0;
      good_nx = '0;
      bad_nx  = '0;
    end else begin
      per_nx = (ref_rise || timeout) ? '0 : cnt_inc[CNT_W-1:0];
      if (ref_rise) begin
        ref_cyc_nx = cnt_inc[CNT_W-1:0];
        valid_nx   = 1'b1;
      end
      if (period_end) begin
        if (period_good) begin
          good_nx = (state == ST_ACQUIRE) ? good_inc : good_cnt;
          bad_nx  = '0;
        end else begin
          err_nx  = 1'b1;
          good_nx = '0;
          bad_nx  = (state == ST_LOCKED) ? bad_inc : '0;
        end
      end
      if (state == ST_LOCKED && state_nx == ST_ACQUIRE) begin
        good_nx = '0;
        bad_nx  = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      per_cnt   <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      REF_CYC   <= '0;
      CNT_VALID <= 1'b0;
      ERR       <= 1'b0;
      LOCK      <= 1'b0;
    end else begin
      per_cnt   <= per_nx;
      good_cnt  <= good_nx;
      bad_cnt   <= bad_nx;
      REF_CYC   <= ref_cyc_nx;
      CNT_VALID <= valid_nx;
      ERR       <= err_nx;
      LOCK      <= (state_nx == ST_LOCKED);
    end
  end

endmodule

// File: tb/tb_pll_lock_detect.sv
// Bench for pll_lock_detect: period-timestamp reference model, per-cycle
// compare, directed lock/unlock scenarios and randomized REF periods.
`timescale 1ns/1ps
module tb_pll_lock_detect;

  localparam int MULT = 8, TOL = 1, LOCK_CNT = 16, UNLOCK_CNT = 2;

  logic       clk = 1'b0, rst = 1'b0, ref_i = 1'b0, en = 1'b0;
  logic       lock, cnt_valid, err;
  logic [7:0] ref_cyc;

  int tests = 0, fails = 0;
  int dut_errs = 0, dut_vlds = 0;

  pll_lock_detect dut (
    .CLK(clk), .RST(rst), .REF(ref_i), .ENb_VCO(en),
    .LOCK(lock), .REF_CYC(ref_cyc), .CNT_VALID(cnt_valid), .ERR(err)
  );

  always #12.5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      if (fails <= 30) $display("FAIL %s at %0t: got %0d, want %0d", name, $time, got, want);
    end
  endtask

  // Reference model: REF rising edges become visible 3 cycles after being
  // sampled; periods are differences of edge timestamps in CLK cycles.
  int   kc, m_last, m_phase, m_good, m_bad, m_cyc, el;
  bit   m_lock, m_vld, m_err, rr, ok;
  logic [4:0] h;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      kc = 0; m_last = 0; m_phase = 0; m_good = 0; m_bad = 0; m_cyc = 0;
      m_lock = 0; m_vld = 0; m_err = 0; h = '0;
    end else begin
      h = {h[3:0], ref_i};
      rr = h[3] & ~h[4];
      kc++;
      m_vld = 0; m_err = 0;
      if (!en) begin
        m_phase = 0; m_good = 0; m_bad = 0; m_lock = 0;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (rr) begin m_phase = 2; m_last = kc; end
      end else begin
        el = kc - m_last;
        if (rr || el == 4 * MULT) begin
          ok = rr && (el >= MULT - TOL) && (el <= MULT + TOL);
          m_last = kc;
          if (rr) begin m_cyc = el; m_vld = 1; end
          if (!ok) m_err = 1;
          if (!m_lock) begin
            if (ok) begin m_good++; if (m_good >= LOCK_CNT) m_lock = 1; end
            else m_good = 0;
          end else if (ok) begin
            m_bad = 0;
          end else begin
            m_bad++;
            if (m_bad >= UNLOCK_CNT) begin m_lock = 0; m_good = 0; m_bad = 0; end
          end
        end
      end
    end
  end

  bit started = 0;
  always @(negedge clk) begin
    if (started) begin
      check("LOCK", lock, m_lock);
      check("REF_CYC", ref_cyc, m_cyc);
      check("CNT_VALID", cnt_valid, m_vld);
      check("ERR", err, m_err);
      if (err) dut_errs++;
      if (cnt_valid) dut_vlds++;
    end
  end

  task automatic run_periods(input int per, input int n);
    for (int p = 0; p < n; p++)
      for (int i = 0; i < per; i++) begin
        @(negedge clk);
        ref_i = (i < per / 2);
      end
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ref_i = 1'b0;
    end
  endtask

  task automatic run_random(input int n);
    int pick, per;
    for (int p = 0; p < n; p++) begin
      pick = $urandom_range(0, 99);
      if (pick < 60)      per = 8;
      else if (pick < 90) per = $urandom_range(6, 11);
      else if (pick < 95) per = 32;
      else                per = $urandom_range(33, 45);
      for (int i = 0; i < per; i++) begin
        @(negedge clk);
        ref_i = (i < per / 2);
        if ($urandom_range(0, 299) == 0) en = 1'b0;
        else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      end
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    @(negedge clk);
    started = 1;
    check("rst_LOCK", lock, 0);
    check("rst_REF_CYC", ref_cyc, 0);
    check("rst_CNT_VALID", cnt_valid, 0);
    check("rst_ERR", err, 0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // Nominal 8-cycle reference: ARM edge plus 16 good captures locks
    run_periods(8, 20);
    check("lockA_LOCK", lock, 1);
    check("lockA_REF_CYC", ref_cyc, 8);
    check("lockA_model", m_lock, 1);

    // Two 10-cycle periods drop lock with two ERR pulses
    dut_errs = 0;
    run_periods(10, 2);
    run_periods(8, 1);
    check("slow_LOCK", lock, 0);
    check("slow_errs", dut_errs, 2);
    check("slow_REF_CYC", ref_cyc, 10);
    run_periods(8, 17);
    check("relock_LOCK", lock, 1);

    // A single 9-cycle period stays within tolerance
    dut_errs = 0;
    run_periods(9, 1);
    run_periods(8, 2);
    check("tol9_LOCK", lock, 1);
    check("tol9_errs", dut_errs, 0);

    // REF stuck low: timeouts at 32 and 64 cycles unlock
    dut_errs = 0;
    hold_low(70);
    check("stuck_LOCK", lock, 0);
    check("stuck_errs", dut_errs, 2);
    check("stuck_model", m_lock, 0);
    run_periods(8, 20);
    check("relock2_LOCK", lock, 1);

    // VCO disable drops lock next cycle; first edge after enable only arms
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("dis_LOCK", lock, 0);
    hold_low(5);
    en = 1'b1;
    dut_vlds = 0;
    run_periods(8, 1);
    check("arm_vlds", dut_vlds, 0);
    run_periods(8, 18);
    check("relock3_LOCK", lock, 1);

    // Asynchronous reset between clock edges while locked
    @(negedge clk);
    ref_i = 1'b0;
    #5 rst = 1'b1;
    #1;
    check("arst_LOCK", lock, 0);
    check("arst_REF_CYC", ref_cyc, 0);
    check("arst_CNT_VALID", cnt_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_periods(8, 18);
    check("relock4_LOCK", lock, 1);
    check("relock4_REF_CYC", ref_cyc, 8);

    // Randomized periods, saturation-coincident edges and enable drops
    run_random(400);
    en = 1'b1;
    run_periods(8, 20);
    check("final_LOCK", lock, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
